// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory-access / write-back stage: bus op
// encodings, FSM state encoding and default widths.
package mem_wb_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int REG_SEL_W_DEF = 3;

  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  // The unused encoding 2'b11 behaves exactly like a NOP.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? MEM_NOP : mode;
  endfunction

endpackage

// File: rtl/mem_wb_stage_mem_bus_if.sv
// Req/ack bus handshake for mem_wb_stage: holds address, write data and request
// until ack. With MEM_WB_TIMEOUT_EN defined, an 8-bit wait counter ends a stuck request.
module mem_bus_if
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef MEM_WB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_start,
  input  logic              I_start_we,
  input  logic [DATA_W-1:0] I_start_addr,
  input  logic [DATA_W-1:0] I_start_wdata,
  output logic              O_mem_req,
  output logic              O_mem_we,
  output logic [DATA_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_wdata,
  input  logic              I_mem_ack,
  output logic              O_xfer_done,
  output logic              O_timeout
);

  logic ack_seen;

  // An ack is only meaningful while a request is outstanding.
  assign ack_seen = O_mem_req & I_mem_ack;

`ifdef MEM_WB_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      wait_cnt <= 8'd0;
    end else if (I_start) begin
      wait_cnt <= 8'd0;
    end else if (O_mem_req && !I_mem_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Fires on the edge that closes the TIMEOUT_CYCLES-th unanswered REQ cycle.
  assign O_timeout = O_mem_req & ~I_mem_ack & (wait_cnt == WAIT_LAST);
`else
  assign O_timeout = 1'b0;
`endif

  assign O_xfer_done = ack_seen | O_timeout;

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      O_mem_req   <= 1'b0;
      O_mem_we    <= 1'b0;
      O_mem_addr  <= '0;
      O_mem_wdata <= '0;
    end else if (I_start) begin
      O_mem_req   <= 1'b1;
      O_mem_we    <= I_start_we;
      O_mem_addr  <= I_start_addr;
      O_mem_wdata <= I_start_wdata;
    end else if (O_xfer_done) begin
      O_mem_req <= 1'b0;
      O_mem_we  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: captures one ALU result, runs at most one
// bus transaction, then pulses register-file / PC write strobes and done.
// Optional MEM_WB_TIMEOUT_EN adds a bus wait timeout and the O_fault output.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_SEL_W = REG_SEL_W_DEF
`ifdef MEM_WB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                 I_clk,
  input  logic                 I_reset_n,
  input  logic                 I_enable,
  input  logic [DATA_W-1:0]    I_alu_out,
  input  logic                 I_write_rD,
  input  logic                 I_write_pc,
  input  logic [1:0]           I_memory_mode,
  input  logic [REG_SEL_W-1:0] I_rD_sel,
  input  logic [DATA_W-1:0]    I_store_data,
  output logic                 O_mem_req,
  output logic                 O_mem_we,
  output logic [DATA_W-1:0]    O_mem_addr,
  output logic [DATA_W-1:0]    O_mem_wdata,
  input  logic                 I_mem_ack,
  input  logic [DATA_W-1:0]    I_mem_rdata,
  output logic                 O_reg_we,
  output logic [REG_SEL_W-1:0] O_reg_sel,
  output logic [DATA_W-1:0]    O_reg_data,
  output logic                 O_pc_we,
  output logic [DATA_W-1:0]    O_pc_data,
  output logic                 O_busy,
  output logic                 O_done
`ifdef MEM_WB_TIMEOUT_EN
  , output logic               O_fault
`endif
);

  state_t               state_q, state_d;
  logic [1:0]           mode_in, mode_q;
  logic                 write_rd_q, write_pc_q;
  logic [REG_SEL_W-1:0] sel_q;
  logic [DATA_W-1:0]    alu_q, data_q;
  logic                 accept, bus_start, xfer_done, timeout;
  logic                 reg_we_d, pc_we_d, done_d;

  assign mode_in   = norm_mode(I_memory_mode);
  assign accept    = (state_q == ST_IDLE) & I_enable;
  assign bus_start = accept & (mode_in != MEM_NOP);

  mem_bus_if #(
    .DATA_W        (DATA_W)
`ifdef MEM_WB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) u_bus (
    .I_clk        (I_clk),
    .I_reset_n    (I_reset_n),
    .I_start      (bus_start),
    .I_start_we   (mode_in == MEM_WRITE),
    .I_start_addr (I_alu_out),
    .I_start_wdata(I_store_data),
    .O_mem_req    (O_mem_req),
    .O_mem_we     (O_mem_we),
    .O_mem_addr   (O_mem_addr),
    .O_mem_wdata  (O_mem_wdata),
    .I_mem_ack    (I_mem_ack),
    .O_xfer_done  (xfer_done),
    .O_timeout    (timeout)
  );

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (I_enable) state_d = (mode_in == MEM_NOP) ? ST_WB : ST_REQ;
      ST_REQ:  if (xfer_done) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe values for the cycle after this edge; registered below so they
  // come straight off flops and cannot glitch.
  always_comb begin
    reg_we_d = 1'b0;
    pc_we_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && mode_in == MEM_NOP) begin
          reg_we_d = I_write_rD;
          pc_we_d  = I_write_pc;
          done_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (xfer_done) begin
          reg_we_d = write_rd_q & (mode_q != MEM_WRITE) & ~timeout;
          pc_we_d  = write_pc_q & ~timeout;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      O_reg_we <= 1'b0;
      O_pc_we  <= 1'b0;
      O_done   <= 1'b0;
      O_busy   <= 1'b0;
    end else begin
      O_reg_we <= reg_we_d;
      O_pc_we  <= pc_we_d;
      O_done   <= done_d;
      O_busy   <= (state_d != ST_IDLE);
    end
  end

`ifdef MEM_WB_TIMEOUT_EN
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) O_fault <= 1'b0;
    else            O_fault <= (state_q == ST_REQ) & timeout;
  end
`endif

  // NOTE: capture registers are reset too, because they drive O_reg_sel,
  // O_reg_data and O_pc_data directly and those must read 0 out of reset.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      mode_q     <= MEM_NOP;
      write_rd_q <= 1'b0;
      write_pc_q <= 1'b0;
      sel_q      <= '0;
      alu_q      <= '0;
      data_q     <= '0;
    end else if (accept) begin
      mode_q     <= mode_in;
      write_rd_q <= I_write_rD;
      write_pc_q <= I_write_pc;
      sel_q      <= I_rD_sel;
      alu_q      <= I_alu_out;
      data_q     <= I_alu_out;
    end else if (state_q == ST_REQ && xfer_done && !timeout && mode_q == MEM_READ) begin
      data_q <= I_mem_rdata;
    end
  end

  assign O_reg_sel  = sel_q;
  assign O_reg_data = data_q;
  assign O_pc_data  = alu_q;

endmodule
